// File: rtl/memory_pkg.sv
// memory_pkg: shared widths, depth and controller state encoding for the memory unit
package memory_pkg;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 256;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   typedef enum logic [1:0] {
      CLEAR,
      IDLE,
      LOAD,
      DONE
   } state_t;
endpackage

// File: rtl/ram_256x16.sv
// ram_256x16: 256x16 storage, one write port, write-first registered read with synchronous output clear
module ram_256x16
   import memory_pkg::*;
(
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              rd_zero,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];
   // storage write port
   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end
   // registered read, bypassing a same-address write and forced to zero when the reader is not served
   always_ff @(posedge clock) begin
      rdata <= rd_zero ? '0 : (we && waddr == raddr) ? wdata : mem[raddr];
   end
endmodule

// File: rtl/memory_unit.sv
// memory_unit: processor memory with power-on clear and a streaming program loader
module memory_unit
   import memory_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] mar,
   input  logic [DATA_W-1:0] data_in,
   input  logic              memory_write,
   output logic [DATA_W-1:0] mdr,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              load_done,
   output logic              busy
);
   state_t            state, nxt;
   logic [ADDR_W-1:0] ptr, waddr;
   logic [DATA_W-1:0] wdata;
   logic              we, xfer, last;
   // write port steering and next-state selection; reset overrides everything and blocks writes
   always_comb begin
      xfer  = state == LOAD && load_valid;
      last  = xfer && (load_last || ptr == LAST_ADDR);
      we    = reset && (state == CLEAR || xfer || (state == IDLE && memory_write));
      waddr = state == IDLE ? mar : ptr;
      wdata = state == CLEAR ? '0 : state == LOAD ? load_data : data_in;
      nxt   = !reset          ? CLEAR :
              state == CLEAR  ? (ptr == LAST_ADDR ? IDLE : CLEAR) :
              state == IDLE   ? (load_start ? LOAD : IDLE) :
              state == LOAD   ? (last ? DONE : LOAD) :
                                IDLE;
   end
   // controller state, shared clear/load pointer and registered status outputs
   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= CLEAR;
         ptr        <= '0;
         load_ready <= 1'b0;
         load_done  <= 1'b0;
         busy       <= 1'b1;
      end else begin
         state      <= nxt;
         ptr        <= state == IDLE ? '0 : (state == CLEAR || (xfer && !last)) ? ptr + 1'b1 : ptr;
         load_ready <= nxt == LOAD;
         load_done  <= nxt == DONE;
         busy       <= nxt != IDLE;
      end
   end
   ram_256x16 u_ram (
      .clock   (clock),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .raddr   (mar),
      .rd_zero (nxt != IDLE),
      .rdata   (mdr)
   );
endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit: randomized and directed checks of memory_unit against a phase-level behavioural model
module tb_memory_unit;
   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  mar;
   logic [15:0] data_in;
   logic        memory_write;
   logic [15:0] mdr;
   logic        load_start;
   logic        load_valid;
   logic [15:0] load_data;
   logic        load_last;
   logic        load_ready;
   logic        load_done;
   logic        busy;
   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   memory_unit dut (
      .clock        (clock),
      .reset        (reset),
      .mar          (mar),
      .data_in      (data_in),
      .memory_write (memory_write),
      .mdr          (mdr),
      .load_start   (load_start),
      .load_valid   (load_valid),
      .load_data    (load_data),
      .load_last    (load_last),
      .load_ready   (load_ready),
      .load_done    (load_done),
      .busy         (busy)
   );
   always #5 clock = ~clock;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   logic [15:0] m_mem [256];
   int          clr_left = 0;
   int          m_ptr = 0;
   bit          m_load = 0;
   bit          m_done = 0;
   bit          ia;
   bit          chk_en = 0;
   logic [15:0] e_mdr;
   bit          e_busy, e_ready, e_done;
   always @(posedge clock) begin
      if (!reset) begin
         clr_left = 256;
         m_load = 0;
         m_done = 0;
         m_ptr = 0;
      end else if (clr_left > 0) begin
         m_mem[256 - clr_left] = 16'h0000;
         clr_left--;
      end else if (m_done) begin
         m_done = 0;
      end else if (m_load) begin
         if (load_valid) begin
            m_mem[m_ptr] = load_data;
            if (load_last || m_ptr == 255) begin
               m_load = 0;
               m_done = 1;
            end else m_ptr++;
         end
      end else begin
         if (memory_write) m_mem[mar] = data_in;
         if (load_start) begin
            m_load = 1;
            m_ptr = 0;
         end
      end
      ia = clr_left == 0 && !m_load && !m_done;
      e_mdr = ia ? m_mem[mar] : 16'h0000;
      e_busy = !ia;
      e_ready = m_load;
      e_done = m_done;
      chk_en = 1;
   end
   always @(negedge clock) begin
      if (chk_en) begin
         chk("mdr", 32'(mdr), 32'(e_mdr));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("load_ready", 32'(load_ready), 32'(e_ready));
         chk("load_done", 32'(load_done), 32'(e_done));
         if (load_done === 1'b1) done_cnt++;
      end
   end
   task automatic step();
      @(negedge clock);
   endtask
   task automatic rd(input logic [7:0] a, input logic [15:0] exp, input string nm);
      mar = a;
      memory_write = 1'b0;
      step();
      chk(nm, 32'(mdr), 32'(exp));
   endtask
   task automatic wr(input logic [7:0] a, input logic [15:0] d);
      mar = a;
      data_in = d;
      memory_write = 1'b1;
      step();
      memory_write = 1'b0;
   endtask
   task automatic wait_clear();
      int n = 0;
      while (busy === 1'b1 && n < 400) begin
         n++;
         step();
      end
      chk("clear_len", 32'(n), 32'd256);
   endtask
   initial begin
      int d0;
      reset = 1'b0;
      mar = '0;
      data_in = '0;
      memory_write = 1'b0;
      load_start = 1'b0;
      load_valid = 1'b0;
      load_data = '0;
      load_last = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      wait_clear();
      rd(8'h00, 16'h0000, "clr_0");
      rd(8'h7F, 16'h0000, "clr_7f");
      rd(8'hFF, 16'h0000, "clr_ff");
      wr(8'h05, 16'h1234);
      rd(8'h05, 16'h1234, "rd_05");
      wr(8'h06, 16'hBEEF);
      chk("wfirst_06", 32'(mdr), 32'h0000BEEF);
      wr(8'h04, 16'hA5A5);
      wr(8'h10, 16'h7777);
      mar = 8'h20;
      data_in = 16'h4242;
      memory_write = 1'b1;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      d0 = done_cnt;
      mar = 8'h10;
      data_in = 16'hFFFF;
      chk("load_mdr0", 32'(mdr), 32'h0);
      chk("load_ready1", 32'(load_ready), 32'h1);
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1;
         load_data = 16'(16'h0101 + i);
         load_last = (i == 3);
         step();
         load_valid = 1'b0;
         load_last = 1'b0;
         if (i < 3) step();
      end
      chk("done_pulse", 32'(load_done), 32'h1);
      memory_write = 1'b0;
      step();
      chk("busy_after_done", 32'(busy), 32'h0);
      chk("done_once", 32'(done_cnt - d0), 32'd1);
      for (int i = 0; i < 4; i++) rd(8'(i), 16'(16'h0101 + i), "loaded");
      rd(8'h04, 16'hA5A5, "kept_04");
      rd(8'h10, 16'h7777, "kept_10");
      rd(8'h20, 16'h4242, "start_write_20");
      d0 = done_cnt;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      for (int i = 0; i < 256; i++) begin
         load_valid = 1'b1;
         load_data = 16'(i * 3 + 16'h1000);
         step();
      end
      load_data = 16'hDEAD;
      repeat (2) step();
      load_valid = 1'b0;
      chk("full_done_once", 32'(done_cnt - d0), 32'd1);
      rd(8'h00, 16'h1000, "full_0_nowrap");
      rd(8'h80, 16'(128 * 3 + 16'h1000), "full_80");
      rd(8'hFF, 16'(255 * 3 + 16'h1000), "full_ff");
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      load_valid = 1'b1;
      load_data = 16'h5555;
      repeat (2) step();
      load_valid = 1'b0;
      reset = 1'b0;
      step();
      reset = 1'b1;
      wait_clear();
      rd(8'h00, 16'h0000, "abort_0");
      rd(8'h01, 16'h0000, "abort_1");
      for (int c = 0; c < 3000; c++) begin
         reset = $urandom_range(0, 399) != 0;
         mar = $urandom_range(0, 1) != 0 ? 8'($urandom_range(0, 15)) : 8'($urandom);
         data_in = 16'($urandom);
         memory_write = $urandom_range(0, 3) == 0;
         load_start = $urandom_range(0, 15) == 0;
         load_valid = $urandom_range(0, 2) != 0;
         load_data = 16'($urandom);
         load_last = $urandom_range(0, 7) == 0;
         step();
      end
      reset = 1'b1;
      memory_write = 1'b0;
      load_start = 1'b0;
      load_valid = 1'b0;
      repeat (300) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/memory_unit.md
MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 clock  input  1  single system clock; all state changes on its rising edge.
REQ-002 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-003 mar  input  8  word address from processor (256 words).
REQ-004 data_in  input  16  write data from processor accumulator.
REQ-005 memory_write  input  1  processor write strobe, active high.
REQ-006 mdr  output  16  registered read data for processor.
REQ-007 load_start  input  1  request to begin a program load, sampled only in IDLE.
REQ-008 load_valid  input  1  loader word valid.
REQ-009 load_data  input  16  loader word.
REQ-010 load_last  input  1  qualifies the final loader word, valid with load_valid.
REQ-011 load_ready  output  1  unit accepts a loader word this cycle.
REQ-012 load_done  output  1  one-cycle pulse at load completion.
REQ-013 busy  output  1  high in CLEAR, LOAD, DONE; processor holds while high.

Function
REQ-014 Storage SHALL be 256 x 16-bit words, one write port, one registered read port.
REQ-015 FSM states SHALL be CLEAR, IDLE, LOAD, DONE.
REQ-016 CLEAR SHALL write 16'h0000 to address 0..255, one word per cycle, then go to IDLE (256 cycles total).
REQ-017 In IDLE, mdr SHALL equal mem[mar] one cycle after mar is presented (latency 1).
REQ-018 In IDLE with memory_write=1, mem[mar] SHALL be written with data_in on that edge.
REQ-019 Read during write to the same address SHALL be write-first: mdr shows data_in on the next cycle.
REQ-020 In IDLE, load_start=1 SHALL move to LOAD with load pointer cleared to 0; memory_write in the same cycle is still honoured.
REQ-021 In LOAD, load_ready SHALL be 1; a word SHALL be written only when load_valid && load_ready, to mem[pointer], pointer incrementing by 1.
REQ-022 LOAD SHALL exit to DONE after a transfer with load_last=1 or after the transfer at pointer 255; the pointer SHALL NOT wrap.
REQ-023 DONE SHALL last exactly one cycle with load_done=1, then go to IDLE.
REQ-024 Words not overwritten by a load SHALL retain prior contents.
REQ-025 In CLEAR, LOAD, DONE: memory_write SHALL be ignored, mdr SHALL be 16'h0000, load_start SHALL be ignored.
REQ-026 load_ready SHALL be 0 outside LOAD; load_valid outside LOAD SHALL be ignored.
REQ-027 load_valid deasserted in LOAD SHALL stall the pointer with no write and no timeout.

Reset
REQ-028 reset=0 on a rising edge SHALL force state CLEAR, clear pointer to 0, and drive mdr=16'h0000, load_ready=0, load_done=0, busy=1.
REQ-029 Reset mid-LOAD or mid-CLEAR SHALL abort and restart CLEAR from address 0; partially loaded words are cleared.
REQ-030 No asynchronous reset paths SHALL exist.

Structure
REQ-031 Package memory_pkg SHALL hold ADDR_W=8, DATA_W=16, DEPTH=256 and the FSM state enum.
REQ-032 The storage array SHALL be a sub-module ram_256x16 (single write port, registered read, write-first); FSM, pointer and port muxing reside in memory_unit.

Verification
REQ-033 Reset release -> busy=1 for exactly 256 cycles, then busy=0; reading addresses 0, 0x7F, 0xFF returns 16'h0000.
REQ-034 IDLE: write 16'h1234 to 0x05, then mar=0x05 -> mdr=16'h1234 one cycle later; same-cycle write/read of 16'hBEEF to 0x06 -> mdr=16'hBEEF next cycle.
REQ-035 load_start, 4 words 16'h0101..16'h0104 with load_last on the 4th and load_valid gapped by one idle cycle -> addresses 0..3 hold those words, load_done pulses once, busy drops the cycle after DONE, address 4 unchanged.
REQ-036 Load 256 words without load_last -> terminates after address 0xFF, load_done pulses, no wrap write to address 0.
REQ-037 memory_write=1 to 0x10 with 16'hFFFF during LOAD -> 0x10 unchanged unless written by the loader; mdr=0 while busy.
REQ-038 reset=0 after 2 loaded words -> CLEAR restarts; after 256 cycles addresses 0,1 read 16'h0000.
